// File: rtl/forward_unit.sv
// Operand-forwarding and load-use stall unit for the ID stage of a 5-stage pipeline.
// Optional performance counters are enabled with `define FWD_PERF_CNT_EN.
module forward_unit (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] inst_i,
    input  logic        re1_i,
    input  logic        re2_i,
    input  logic        id_valid_i,
    input  logic        id_we_i,
    input  logic [1:0]  id_wd_sel_i,
    input  logic        flush_i,
    input  logic [31:0] ex_alu_result_i,
    input  logic [31:0] ex_return_pc_i,
    input  logic [31:0] mem_alu_result_i,
    input  logic [31:0] mem_return_pc_i,
    input  logic [31:0] mem_rdata_i,
    input  logic [31:0] wb_wd_i,
    output logic        r1_select_o,
    output logic        r2_select_o,
    output logic [31:0] forward_data_1_o,
    output logic [31:0] forward_data_2_o,
    output logic        stall_o
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] fwd_cnt_o
`endif
);

    localparam logic [1:0] RETURN_PC  = 2'b00;
    localparam logic [1:0] ALU_RESULT = 2'b01;
    localparam logic [1:0] MEM_DATA   = 2'b10;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [1:0] wd_sel;
    } sb_entry_t;

    typedef struct packed {
        logic        hit;
        logic        stall;
        logic [31:0] data;
    } fwd_t;

    sb_entry_t ex_q, mem_q, wb_q;
    fwd_t      fwd_1, fwd_2;

    logic [4:0] rs1, rs2;
    assign rs1 = inst_i[19:15];
    assign rs2 = inst_i[24:20];

    logic unused_inst;
    assign unused_inst = ^{inst_i[31:25], inst_i[14:12], inst_i[6:0]};

    function automatic logic live(input sb_entry_t e, input logic [4:0] rs);
        return e.v && (e.rd != 5'd0) && (e.rd == rs);
    endfunction

    // Youngest matching entry wins; an EX load matches but cannot forward yet, so it stalls.
    function automatic fwd_t resolve(
        input logic [4:0]  rs,
        input logic        re,
        input sb_entry_t   ex_e,
        input sb_entry_t   mem_e,
        input sb_entry_t   wb_e,
        input logic [31:0] ex_alu,
        input logic [31:0] ex_pc,
        input logic [31:0] mem_alu,
        input logic [31:0] mem_pc,
        input logic [31:0] mem_rdata,
        input logic [31:0] wb_wd
    );
        fwd_t r;
        r = '0;
        if (re && rs != 5'd0) begin
            if (live(ex_e, rs)) begin
                unique case (ex_e.wd_sel)
                    ALU_RESULT: begin r.hit = 1'b1; r.data = ex_alu; end
                    RETURN_PC:  begin r.hit = 1'b1; r.data = ex_pc;  end
                    MEM_DATA:   r.stall = 1'b1;
                    default:    r.hit = 1'b1;
                endcase
            end else if (live(mem_e, rs)) begin
                r.hit = 1'b1;
                unique case (mem_e.wd_sel)
                    ALU_RESULT: r.data = mem_alu;
                    RETURN_PC:  r.data = mem_pc;
                    MEM_DATA:   r.data = mem_rdata;
                    default:    r.data = 32'd0;
                endcase
            end else if (live(wb_e, rs)) begin
                r.hit  = 1'b1;
                r.data = wb_wd;
            end
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every output gets a value on every path through this block, so no latch is inferred.
        fwd_1 = resolve(rs1, re1_i, ex_q, mem_q, wb_q, ex_alu_result_i, ex_return_pc_i,
                        mem_alu_result_i, mem_return_pc_i, mem_rdata_i, wb_wd_i);
        fwd_2 = resolve(rs2, re2_i, ex_q, mem_q, wb_q, ex_alu_result_i, ex_return_pc_i,
                        mem_alu_result_i, mem_return_pc_i, mem_rdata_i, wb_wd_i);
        r1_select_o      = fwd_1.hit;
        r2_select_o      = fwd_2.hit;
        forward_data_1_o = fwd_1.data;
        forward_data_2_o = fwd_2.data;
        stall_o          = id_valid_i && (fwd_1.stall || fwd_2.stall);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read its predecessor's old value.
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= '{v:      id_valid_i && id_we_i && !stall_o && !flush_i,
                       rd:     inst_i[11:7],
                       wd_sel: id_wd_sel_i};
        end
    end

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cnt_o <= 32'd0;
            fwd_cnt_o   <= 32'd0;
        end else begin
            if (stall_o)                     stall_cnt_o <= stall_cnt_o + 32'd1;
            if (r1_select_o || r2_select_o)  fwd_cnt_o   <= fwd_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_forward_unit.sv
// Directed bench for forward_unit: expected outputs are queued per step and
// compared at the following falling edge.
module tb_forward_unit;

    localparam logic [1:0] RETURN_PC  = 2'b00;
    localparam logic [1:0] ALU_RESULT = 2'b01;
    localparam logic [1:0] MEM_DATA   = 2'b10;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] inst_i;
    logic        re1_i, re2_i, id_valid_i, id_we_i, flush_i;
    logic [1:0]  id_wd_sel_i;
    logic [31:0] ex_alu_result_i, ex_return_pc_i;
    logic [31:0] mem_alu_result_i, mem_return_pc_i, mem_rdata_i, wb_wd_i;
    logic        r1_select_o, r2_select_o, stall_o;
    logic [31:0] forward_data_1_o, forward_data_2_o;

    typedef struct {
        string       tag;
        logic        sel1;
        logic        sel2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int   test_cnt = 0;
    int   fail_cnt = 0;

    always #5 clk_i = ~clk_i;

    forward_unit dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .inst_i           (inst_i),
        .re1_i            (re1_i),
        .re2_i            (re2_i),
        .id_valid_i       (id_valid_i),
        .id_we_i          (id_we_i),
        .id_wd_sel_i      (id_wd_sel_i),
        .flush_i          (flush_i),
        .ex_alu_result_i  (ex_alu_result_i),
        .ex_return_pc_i   (ex_return_pc_i),
        .mem_alu_result_i (mem_alu_result_i),
        .mem_return_pc_i  (mem_return_pc_i),
        .mem_rdata_i      (mem_rdata_i),
        .wb_wd_i          (wb_wd_i),
        .r1_select_o      (r1_select_o),
        .r2_select_o      (r2_select_o),
        .forward_data_1_o (forward_data_1_o),
        .forward_data_2_o (forward_data_2_o),
        .stall_o          (stall_o)
    );

    task automatic id_drive(input logic valid, input logic we, input logic [1:0] wsel,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic re1, input logic re2, input logic flush);
        id_valid_i  = valid;
        id_we_i     = we;
        id_wd_sel_i = wsel;
        inst_i      = {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
        re1_i       = re1;
        re2_i       = re2;
        flush_i     = flush;
    endtask

    task automatic data_drive(input logic [31:0] ex_alu, input logic [31:0] ex_pc,
                              input logic [31:0] mem_alu, input logic [31:0] mem_pc,
                              input logic [31:0] mem_rd, input logic [31:0] wb_wd);
        ex_alu_result_i  = ex_alu;
        ex_return_pc_i   = ex_pc;
        mem_alu_result_i = mem_alu;
        mem_return_pc_i  = mem_pc;
        mem_rdata_i      = mem_rd;
        wb_wd_i          = wb_wd;
    endtask

    task automatic expect_out(input string tag, input logic s1, input logic s2,
                              input logic [31:0] d1, input logic [31:0] d2, input logic st);
        exp_t e;
        e.tag = tag; e.sel1 = s1; e.sel2 = s2; e.d1 = d1; e.d2 = d2; e.stall = st;
        exp_q.push_back(e);
    endtask

    task automatic check_fields(input string tag, input logic [31:0] got, input logic [31:0] want);
        test_cnt++;
        assert (got === want) else begin
            fail_cnt++;
            $error("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    // Compare every queued expectation against the settled outputs at the falling edge.
    task automatic compare_pending();
        exp_t e;
        @(negedge clk_i);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_fields({e.tag, ".r1_select"}, {31'd0, r1_select_o}, {31'd0, e.sel1});
            check_fields({e.tag, ".r2_select"}, {31'd0, r2_select_o}, {31'd0, e.sel2});
            check_fields({e.tag, ".data1"},     forward_data_1_o,     e.d1);
            check_fields({e.tag, ".data2"},     forward_data_2_o,     e.d2);
            check_fields({e.tag, ".stall"},     {31'd0, stall_o},     {31'd0, e.stall});
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i = 1'b0;
        id_drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        data_drive('0, '0, '0, '0, '0, '0);
        repeat (2) @(posedge clk_i);
        #1;
        expect_out("reset_held", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        compare_pending();
        reset_i = 1'b1;
        next_cycle();

        // Reset released, empty pipeline, ID issues addi x5.
        id_drive(1'b1, 1'b1, ALU_RESULT, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_out("after_reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        compare_pending();
        next_cycle();

        // add x6,x5,x5 with x5 in EX.
        id_drive(1'b1, 1'b1, ALU_RESULT, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        data_drive(32'h11, 32'hA0, 32'hB0, 32'hB4, 32'hC0, 32'hD0);
        expect_out("ex_alu_fwd", 1'b1, 1'b1, 32'h11, 32'h11, 1'b0);
        compare_pending();
        next_cycle();

        // lw x7, no reads.
        id_drive(1'b1, 1'b1, MEM_DATA, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_out("lw_issue", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        compare_pending();
        next_cycle();

        // add x8,x7,x0 right behind the load -> stall.
        id_drive(1'b1, 1'b1, ALU_RESULT, 5'd8, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0);
        expect_out("load_use_stall", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        compare_pending();
        next_cycle();

        // Held instruction: load now in MEM, bubble in EX.
        data_drive(32'h0BAD, 32'h0BAD, 32'h0BAD, 32'h0BAD, 32'hDEAD_BEEF, 32'h0BAD);
        expect_out("load_mem_fwd", 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        compare_pending();
        next_cycle();

        // Two writes of x3, then a read of x3 (EX and MEM) and x8 (WB).
        id_drive(1'b1, 1'b1, ALU_RESULT, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        id_drive(1'b1, 1'b1, ALU_RESULT, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        id_drive(1'b1, 1'b0, ALU_RESULT, 5'd0, 5'd3, 5'd8, 1'b1, 1'b1, 1'b0);
        data_drive(32'h2, 32'h0, 32'h1, 32'h0, 32'h0, 32'h88);
        expect_out("prio_ex_over_mem", 1'b1, 1'b1, 32'h2, 32'h88, 1'b0);
        compare_pending();
        next_cycle();
        id_drive(1'b1, 1'b0, ALU_RESULT, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();

        // x3 only in WB; rs2 reads x3 but is disabled.
        id_drive(1'b1, 1'b0, ALU_RESULT, 5'd0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
        data_drive(32'h2, 32'h0, 32'h1, 32'h0, 32'h0, 32'h3);
        expect_out("prio_wb_only", 1'b1, 1'b0, 32'h3, 32'h0, 1'b0);
        compare_pending();
        next_cycle();

        // Load into x0, then read x0 while flushing an instruction that writes x9.
        id_drive(1'b1, 1'b1, MEM_DATA, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        id_drive(1'b1, 1'b1, ALU_RESULT, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        data_drive(32'h55, 32'h55, 32'h55, 32'h55, 32'h55, 32'h55);
        expect_out("x0_read", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        compare_pending();
        next_cycle();
        id_drive(1'b0, 1'b0, ALU_RESULT, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        id_drive(1'b1, 1'b0, ALU_RESULT, 5'd0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
        data_drive(32'h97, 32'h97, 32'h98, 32'h98, 32'h98, 32'h99);
        expect_out("flushed_x9", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        compare_pending();
        next_cycle();

        // jal x1, consumer in EX then MEM.
        id_drive(1'b1, 1'b1, RETURN_PC, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        id_drive(1'b1, 1'b0, ALU_RESULT, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
        data_drive(32'h0BAD, 32'h104, 32'h0, 32'h0, 32'h0, 32'h0);
        expect_out("jal_ex_fwd", 1'b1, 1'b1, 32'h104, 32'h104, 1'b0);
        compare_pending();
        next_cycle();
        data_drive(32'h0, 32'h0, 32'h0BAD, 32'h204, 32'h0BAD, 32'h0);
        expect_out("jal_mem_fwd", 1'b1, 1'b1, 32'h204, 32'h204, 1'b0);
        compare_pending();
        next_cycle();

        // Load-use coinciding with flush: stall still visible, bubble enters EX.
        id_drive(1'b1, 1'b1, MEM_DATA, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        id_drive(1'b1, 1'b1, ALU_RESULT, 5'd14, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1);
        expect_out("flush_and_stall", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        compare_pending();
        next_cycle();
        id_drive(1'b1, 1'b0, ALU_RESULT, 5'd0, 5'd0, 5'd10, 1'b0, 1'b1, 1'b0);
        data_drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h1234, 32'h0);
        expect_out("after_flush_mem", 1'b0, 1'b1, 32'h0, 32'h1234, 1'b0);
        compare_pending();
        next_cycle();

        // Load in EX but ID is not valid: no stall, no forward.
        id_drive(1'b1, 1'b1, MEM_DATA, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        id_drive(1'b0, 1'b0, ALU_RESULT, 5'd0, 5'd11, 5'd11, 1'b1, 1'b1, 1'b0);
        expect_out("invalid_id_no_stall", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        compare_pending();
        next_cycle();

        // Undefined wd_sel in EX masks the older ALU write in MEM.
        id_drive(1'b1, 1'b1, ALU_RESULT, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        id_drive(1'b1, 1'b1, 2'b11, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        id_drive(1'b1, 1'b0, ALU_RESULT, 5'd0, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0);
        data_drive(32'h66, 32'h66, 32'h77, 32'h77, 32'h77, 32'h88);
        expect_out("undef_wdsel", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        compare_pending();
        next_cycle();

        // Mid-operation reset drops the in-flight x13 immediately.
        id_drive(1'b1, 1'b1, ALU_RESULT, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        id_drive(1'b1, 1'b0, ALU_RESULT, 5'd0, 5'd13, 5'd13, 1'b1, 1'b1, 1'b0);
        data_drive(32'h13, 32'h13, 32'h13, 32'h13, 32'h13, 32'h13);
        expect_out("pre_reset_fwd", 1'b1, 1'b1, 32'h13, 32'h13, 1'b0);
        #1;
        reset_i = 1'b0;
        expect_out("async_reset_drop", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        exp_q.delete(0);
        compare_pending();
        #1;
        reset_i = 1'b1;
        next_cycle();
        expect_out("after_reset_drop", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        compare_pending();

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
